// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUN/PAUSE/LAP FSM,
// count-tick prescaler and 7-segment digit scan, all on a single clock.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 500000,
  parameter int DB_CYCLES = 1000000,
  parameter int SCAN_DIV  = 131072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state,
  output logic [3:0] digit
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t state_reg;
  logic [2:0] raw;
  logic [2:0] press;
  logic win_ss, win_clr, win_lap;
  logic [TW-1:0] pre_cnt_reg;
  logic [SW-1:0] scan_cnt_reg;

  assign raw   = {btn_lap, btn_clr, btn_ss};
  assign state = state_reg;

  // Per button: 2-FF synchroniser, stability counter, registered press pulse.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic sync1_reg, sync2_reg, stable_reg, press_reg;
    logic [DW-1:0] db_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_reg  <= 1'b0;
        sync2_reg  <= 1'b0;
        stable_reg <= 1'b0;
        press_reg  <= 1'b0;
        db_cnt_reg <= '0;
      end else begin
        sync1_reg <= raw[gi];
        sync2_reg <= sync1_reg;
        press_reg <= 1'b0;
        if (sync2_reg == stable_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          stable_reg <= sync2_reg;
          db_cnt_reg <= '0;
          press_reg  <= sync2_reg;
        end else begin
          db_cnt_reg <= db_cnt_reg + DW'(1);
        end
      end
    end

    assign press[gi] = press_reg;
  end

  // Only the highest-priority simultaneous press survives.
  assign win_ss  = press[0];
  assign win_clr = press[1] & ~press[0];
  assign win_lap = press[2] & ~press[1] & ~press[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      running   <= 1'b0;
      lap_hold  <= 1'b0;
      cnt_clr   <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_ss) begin
            state_reg <= RUN;
            running   <= 1'b1;
          end else if (win_clr) begin
            cnt_clr <= 1'b1;
          end
        end
        RUN: begin
          if (win_ss) begin
            state_reg <= PAUSE;
            running   <= 1'b0;
          end else if (win_lap) begin
            state_reg <= LAP;
            lap_hold  <= 1'b1;
          end
        end
        LAP: begin
          if (win_ss) begin
            state_reg <= PAUSE;
            running   <= 1'b0;
            lap_hold  <= 1'b0;
          end else if (win_lap) begin
            state_reg <= RUN;
            lap_hold  <= 1'b0;
          end
        end
        PAUSE: begin
          if (win_ss) begin
            state_reg <= RUN;
            running   <= 1'b1;
          end else if (win_clr) begin
            state_reg <= IDLE;
            cnt_clr   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          running   <= 1'b0;
          lap_hold  <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler is cleared whenever stopped, so a pause drops the partial interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_reg <= '0;
      tick_en     <= 1'b0;
    end else begin
      tick_en <= 1'b0;
      if (!running) begin
        pre_cnt_reg <= '0;
      end else if (pre_cnt_reg == TICK_LAST) begin
        pre_cnt_reg <= '0;
        tick_en     <= 1'b1;
      end else begin
        pre_cnt_reg <= pre_cnt_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_reg <= '0;
      digit        <= 4'b0001;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      digit        <= {digit[2:0], digit[3]};
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; tick and clear pulses are scored against
// queues of expected clock-edge indices filled before each stimulus step.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_lap = 1'b0;
  logic       tick_en, cnt_clr, lap_hold, running;
  logic [1:0] state;
  logic [3:0] digit;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_q[$];
  int clr_q[$];
  int exp_tick, exp_clr;

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .DB_CYCLES(3),
    .SCAN_DIV (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .btn_lap (btn_lap),
    .tick_en (tick_en),
    .cnt_clr (cnt_clr),
    .lap_hold(lap_hold),
    .running (running),
    .state   (state),
    .digit   (digit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ticks(input int start, input int last);
    for (int t = start + 4; t <= last; t += 4) tick_q.push_back(t);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_s);
    chk({tag, "_state"}, state, exp_s);
    chk({tag, "_running"}, running, (exp_s == 2'b01 || exp_s == 2'b11));
    chk({tag, "_lap_hold"}, lap_hold, (exp_s == 2'b11));
  endtask

  // Clean press: raw edge now, state must move exactly 6 edges later. 18 cycles.
  task automatic press_btns(input string tag, input logic [2:0] mask,
                            input logic [1:0] old_s, input logic [1:0] new_s);
    {btn_lap, btn_clr, btn_ss} = mask;
    repeat (5) @(negedge clk);
    chk({tag, "_before"}, state, old_s);
    @(negedge clk);
    chk_state(tag, new_s);
    repeat (4) @(negedge clk);
    {btn_lap, btn_clr, btn_ss} = 3'b000;
    repeat (8) @(negedge clk);
    chk_state({tag, "_after"}, new_s);
    $display("step %s mask=%b state=%b", tag, mask, state);
  endtask

  // Bounce 1,0,1 then held on start/stop; one press 5 edges after final rise. 20 cycles.
  task automatic bounce_ss(input string tag, input logic [1:0] old_s, input logic [1:0] new_s);
    btn_ss = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0;
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (5) @(negedge clk);
    chk({tag, "_before"}, state, old_s);
    @(negedge clk);
    chk_state(tag, new_s);
    repeat (4) @(negedge clk);
    btn_ss = 1'b0;
    repeat (8) @(negedge clk);
    chk_state({tag, "_after"}, new_s);
    $display("step %s state=%b", tag, state);
  endtask

  // Short glitch must not register as a press. 12 cycles.
  task automatic glitch_ss(input string tag, input logic [1:0] cur_s);
    btn_ss = 1'b1;
    repeat (2) @(negedge clk);
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
    chk_state(tag, cur_s);
    $display("step %s state=%b", tag, state);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (tick_en) begin
        if (tick_q.size() > 0) exp_tick = tick_q.pop_front();
        else exp_tick = -1;
        chk("tick_cycle", cyc, exp_tick);
      end
      if (cnt_clr) begin
        if (clr_q.size() > 0) exp_clr = clr_q.pop_front();
        else exp_clr = -1;
        chk("clr_cycle", cyc, exp_clr);
      end
    end
  end

  initial begin
    logic [3:0] exp_digit;
    int e;

    repeat (3) @(negedge clk);
    chk_state("reset", 2'b00);
    chk("reset_tick", tick_en, 1'b0);
    chk("reset_clr", cnt_clr, 1'b0);
    chk("reset_digit", digit, 4'b0001);
    rst = 1'b1;

    // Digit scan steps every 2 edges after reset release.
    exp_digit = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      chk("digit_even", digit, exp_digit);
      chk("idle_state", state, 2'b00);
      @(negedge clk);
      chk("digit_odd", digit, exp_digit);
      @(negedge clk);
      exp_digit = {exp_digit[2:0], exp_digit[3]};
      $display("scan step %0d digit=%b", k, digit);
    end

    // Run 1: RUN at e+6, PAUSE at e+92 via glitch/lap/lap/lap/bounce sequence.
    e = cyc;
    push_ticks(e + 6, e + 92);
    press_btns("ss_idle_run", 3'b001, 2'b00, 2'b01);
    glitch_ss("glitch_run", 2'b01);
    press_btns("lap_run_lap", 3'b100, 2'b01, 2'b11);
    press_btns("lap_lap_run", 3'b100, 2'b11, 2'b01);
    press_btns("lap_run_lap2", 3'b100, 2'b01, 2'b11);
    bounce_ss("ss_lap_pause", 2'b11, 2'b10);
    chk("run1_ticks_pending", tick_q.size(), 0);

    // PAUSE clear, then run 2 with an ignored clear.
    e = cyc;
    clr_q.push_back(e + 6);
    press_btns("clr_pause_idle", 3'b010, 2'b10, 2'b00);
    chk("clr1_pending", clr_q.size(), 0);
    e = cyc;
    push_ticks(e + 6, e + 43);
    press_btns("ss_idle_run2", 3'b001, 2'b00, 2'b01);
    press_btns("clr_run_ignored", 3'b010, 2'b01, 2'b01);
    @(negedge clk);
    press_btns("ss_run_pause", 3'b001, 2'b01, 2'b10);
    chk("run2_ticks_pending", tick_q.size(), 0);

    // Simultaneous ss+clr in PAUSE: ss wins, then reset mid-interval.
    e = cyc;
    push_ticks(e + 6, e + 21);
    press_btns("ss_clr_pause", 3'b011, 2'b10, 2'b01);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state("midrun_reset", 2'b00);
    chk("midrun_reset_tick", tick_en, 1'b0);
    chk("midrun_reset_clr", cnt_clr, 1'b0);
    chk("midrun_reset_digit", digit, 4'b0001);
    chk("run3_ticks_pending", tick_q.size(), 0);
    $display("step midrun_reset state=%b digit=%b", state, digit);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk_state("post_reset", 2'b00);
    chk("final_ticks_pending", tick_q.size(), 0);
    chk("final_clr_pending", clr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
